// File: rtl/csr_rmw_pkg.sv
// csr_rmw_pkg: FSM state type and funct3 encodings shared by the CSR read-modify-write unit.
package csr_rmw_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;
endpackage

// File: rtl/csr_rmw_alu.sv
// csr_rmw_alu: combinational new-value, write-needed and illegal-encoding decode for CSR instructions.
module csr_rmw_alu
  import csr_rmw_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  input  logic [4:0]      zimm,
  output logic [XLEN-1:0] new_val,
  output logic            wr_needed,
  output logic            illegal
);
  logic rw, rs, rc;
  always_comb begin
    rw = funct3 == F3_RW || funct3 == F3_RWI;
    rs = funct3 == F3_RS || funct3 == F3_RSI;
    rc = funct3 == F3_RC || funct3 == F3_RCI;
    illegal = !(rw || rs || rc);
    new_val = rw ? operand : rs ? (old_val | operand) : rc ? (old_val & ~operand) : old_val;
    // set/clear with a zero source field must not write (avoids side effects on read-only CSRs)
    wr_needed = rw || ((rs || rc) && zimm != 5'd0);
  end
endmodule

// File: rtl/csr_rmw_unit.sv
// csr_rmw_unit: 4-cycle CSR read-modify-write sequencer (IDLE->READ->WRITE->RESP).
// Define CSR_RMW_RO_CHECK_EN to block writes to read-only CSRs (addr[11:10]==2'b11) and flag resp_err.
module csr_rmw_unit
  import csr_rmw_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [4:0]        req_zimm,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err,
  output logic              write,
  output logic [ADDR_W-1:0] wrAddr_CSR,
  output logic [XLEN-1:0]   wrVal_CSR,
  output logic [ADDR_W-1:0] rdAddr_CSR,
  input  logic [XLEN-1:0]   rdVal_CSR
);
  state_t            state, state_d;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   rs1_q, old_q, operand, new_val;
  logic [4:0]        zimm_q;
  logic              wr_needed, illegal, ro, err_q;

  assign operand    = f3_q[2] ? {{(XLEN-5){1'b0}}, zimm_q} : rs1_q;
  assign rdAddr_CSR = addr_q;
  assign wrAddr_CSR = addr_q;
  assign wrVal_CSR  = new_val;
  assign resp_data  = old_q;

`ifdef CSR_RMW_RO_CHECK_EN
  assign ro = wr_needed && addr_q[ADDR_W-1 -: 2] == 2'b11;
`else
  assign ro = 1'b0;
`endif

  csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .funct3   (f3_q),
    .old_val  (old_q),
    .operand  (operand),
    .zimm     (zimm_q),
    .new_val  (new_val),
    .wr_needed(wr_needed),
    .illegal  (illegal)
  );

  always_comb begin
    state_d    = state;
    req_ready  = 1'b0;
    write      = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    state_d    = (state == IDLE && req_valid) ? READ :
                 (state == READ)              ? WRITE :
                 (state == WRITE)             ? RESP :
                 (state == RESP && resp_ready) ? IDLE : state;
    req_ready  = state == IDLE;
    write      = state == WRITE && wr_needed && !illegal && !ro;
    resp_valid = state == RESP;
    resp_err   = resp_valid && err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      f3_q   <= '0;
      addr_q <= '0;
      rs1_q  <= '0;
      zimm_q <= '0;
      old_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && req_valid) begin
        f3_q   <= req_funct3;
        addr_q <= req_addr;
        rs1_q  <= req_rs1;
        zimm_q <= req_zimm;
      end
      if (state == READ) old_q <= rdVal_CSR;
      if (state == WRITE) err_q <= illegal || ro;
    end
  end
endmodule

// File: tb/tb_csr_rmw_unit.sv
// tb_csr_rmw_unit: randomized and directed checks of csr_rmw_unit against a CSR-file model.
module tb_csr_rmw_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, write;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr, wrAddr_CSR, rdAddr_CSR;
  logic [31:0] req_rs1, resp_data, wrVal_CSR, rdVal_CSR;
  logic [4:0]  req_zimm;

  logic [31:0] mem [0:4095];
  int checks = 0, errors = 0, cyc = 0;
  int stage = 0, wr_count = 0, acc_cyc = 0, wr_cyc = 0, resp_cyc = 0;
  logic        prev_rv = 1'b0;
  logic [2:0]  m_f3;
  logic [11:0] m_addr;
  logic [31:0] m_old, m_new, last_wr_val, last_resp_data;
  logic [11:0] last_wr_addr;
  logic        m_wr, m_err, last_resp_err;

  csr_rmw_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1(req_rs1), .req_zimm(req_zimm),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .write(write), .wrAddr_CSR(wrAddr_CSR), .wrVal_CSR(wrVal_CSR),
    .rdAddr_CSR(rdAddr_CSR), .rdVal_CSR(rdVal_CSR)
  );

  always #5 clk = ~clk;
  assign rdVal_CSR = mem[rdAddr_CSR];
  always @(posedge clk) if (write) mem[wrAddr_CSR] = wrVal_CSR;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] old,
                                input logic [31:0] rs1, input logic [4:0] z,
                                output logic [31:0] nv, output logic wr, output logic er);
    logic [31:0] op;
    op = f3[2] ? {27'd0, z} : rs1;
    nv = old; wr = 1'b0; er = 1'b0;
    case (f3[1:0])
      2'b01: begin nv = op; wr = 1'b1; end
      2'b10: begin nv = old | op; wr = z != 0; end
      2'b11: begin nv = old & ~op; wr = z != 0; end
      default: er = 1'b1;
    endcase
`ifdef CSR_RMW_RO_CHECK_EN
    if (wr && a[11:10] == 2'b11) begin wr = 1'b0; er = 1'b1; end
`endif
  endfunction

  // Model timeline: accept, read cycle, write cycle, response held until consumed.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_write", write, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_resp_data", resp_data, 0);
      stage = 0;
      prev_rv = 1'b0;
    end else begin
      check("req_ready", req_ready, stage == 0);
      check("write", write, stage == 2 && m_wr);
      check("resp_valid", resp_valid, stage == 3);
      if (stage != 0) check("rd_addr", rdAddr_CSR, m_addr);
      if (stage == 2 && m_wr) begin
        check("wr_addr", wrAddr_CSR, m_addr);
        check("wr_val", wrVal_CSR, m_new);
      end
      if (stage == 3) begin
        check("resp_data", resp_data, m_old);
        check("resp_err", resp_err, m_err);
      end
      if (write) begin wr_count++; last_wr_addr = wrAddr_CSR; last_wr_val = wrVal_CSR; wr_cyc = cyc; end
      if (resp_valid && !prev_rv) resp_cyc = cyc;
      prev_rv = resp_valid;
      case (stage)
        0: if (req_valid) begin
             m_f3 = req_funct3; m_addr = req_addr; m_old = mem[req_addr];
             model(req_funct3, req_addr, m_old, req_rs1, req_zimm, m_new, m_wr, m_err);
             acc_cyc = cyc; stage = 1;
           end
        1: stage = 2;
        2: stage = 3;
        default: if (resp_ready) begin
             last_resp_data = resp_data; last_resp_err = resp_err; stage = 0;
           end
      endcase
    end
  end

  task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] r,
                        input logic [4:0] z, input int hold);
    int n;
    logic [31:0] d0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_rs1 = r; req_zimm = z;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    check("accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_funct3 = 3'($urandom); req_addr = 12'($urandom);
    req_rs1 = $urandom; req_zimm = 5'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    check("resp_seen", resp_valid, 1);
    d0 = resp_data;
    repeat (hold) begin
      @(negedge clk);
      check("stall_ready", req_ready, 0);
      check("stall_valid", resp_valid, 1);
      check("stall_data", resp_data, d0);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] nv;
    logic wr, er;
    int n0, n;
    logic [11:0] al [6];
    al = '{12'h300, 12'h305, 12'h340, 12'hC00, 12'hC01, 12'h7C0};
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_funct3 = '0; req_addr = '0; req_rs1 = '0; req_zimm = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    model(3'b010, 12'h300, 32'h8, 32'h3, 5'd5, nv, wr, er);
    check("model_rs_val", nv, 32'hB); check("model_rs_wr", wr, 1);
    model(3'b111, 12'h300, 32'hFF, 32'h0, 5'h0F, nv, wr, er);
    check("model_rci_val", nv, 32'hF0);
    model(3'b100, 12'h300, 32'h1, 32'h2, 5'd1, nv, wr, er);
    check("model_illegal", {wr, er}, 2'b01);

    mem[12'h340] = 32'hF0; n0 = wr_count;
    do_req(3'b001, 12'h340, 32'h1234, 5'd0, 0);
    check("rw_resp", last_resp_data, 32'hF0);
    check("rw_wcount", wr_count - n0, 1);
    check("rw_waddr", last_wr_addr, 12'h340);
    check("rw_wval", last_wr_val, 32'h1234);
    check("rw_wr_lat", wr_cyc - acc_cyc, 2);
    check("rw_resp_lat", resp_cyc - acc_cyc, 3);

    mem[12'h300] = 32'h8;
    do_req(3'b010, 12'h300, 32'h3, 5'd5, 0);
    check("rs_wval", last_wr_val, 32'hB); check("rs_resp", last_resp_data, 32'h8);
    do_req(3'b011, 12'h300, 32'h8, 5'd5, 0);
    check("rc_wval", last_wr_val, 32'h3); check("rc_resp", last_resp_data, 32'hB);

    mem[12'h305] = 32'h100; n0 = wr_count;
    do_req(3'b110, 12'h305, $urandom, 5'd0, 0);
    check("rsi0_wcount", wr_count - n0, 0);
    check("rsi0_resp", last_resp_data, 32'h100); check("rsi0_err", last_resp_err, 0);

    mem[12'hC00] = 32'h5; n0 = wr_count;
    do_req(3'b001, 12'hC00, 32'h77, 5'd0, 0);
    check("ro_resp", last_resp_data, 32'h5);
`ifdef CSR_RMW_RO_CHECK_EN
    check("ro_wcount", wr_count - n0, 0); check("ro_err", last_resp_err, 1);
`else
    check("ro_wcount", wr_count - n0, 1); check("ro_err", last_resp_err, 0);
`endif

    n0 = wr_count;
    do_req(3'b000, 12'h300, 32'h1, 5'd1, 0);
    check("f3_000_err", last_resp_err, 1);
    do_req(3'b100, 12'h300, 32'h1, 5'd1, 0);
    check("f3_100_err", last_resp_err, 1); check("illegal_wcount", wr_count - n0, 0);

    do_req(3'b010, 12'h340, 32'hF, 5'd3, 5);

    mem[12'h340] = 32'hAAAA; n0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340; req_rs1 = 32'h5555; req_zimm = 5'd0;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    check("rst_accept", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", resp_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_mem", mem[12'h340], 32'hAAAA);
    check("rst_mid_wcount", wr_count - n0, 0);
    check("rst_mid_rv", resp_valid, 0);

    for (int i = 0; i < 300; i++)
      do_req(3'($urandom_range(0, 7)), ($urandom % 3 == 0) ? 12'($urandom) : al[$urandom_range(0, 5)],
             $urandom, ($urandom % 4 == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 3));

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
